// File: rtl/key_buzzer_ctrl.sv
// key_buzzer_ctrl: key-driven passive buzzer controller, 8-note scale C4..C5
//   BEEP_CYCLES  beep duration in clock cycles (>= 1)
//   clk          system clock (50 MHz)
//   rst_n        asynchronous active-low reset
//   key_flag     one-cycle strobe qualifying key_value
//   key_value    debounced key levels, 0 = pressed (110 next, 101 prev, 011 play/stop)
//   beep         registered square-wave buzzer drive
//   note_idx     registered current note index 0..7
//   busy         registered, high while a beep is playing
module key_buzzer_ctrl #(
    parameter int BEEP_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_flag,
    input  logic [2:0] key_value,
    output logic       beep,
    output logic [2:0] note_idx,
    output logic       busy
);
    localparam int DW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;

    logic [0:0]    state, state_n;
    logic [17:0]   pwm_cnt, pwm_n, per;
    logic [DW-1:0] dur_cnt, dur_n;
    logic [2:0]    note_n;
    logic          is_next, is_prev, is_ply, start, stop, expire, beep_n;

    function automatic logic [17:0] period(input logic [2:0] i);
        case (i)
            3'd0:    period = 18'd191112;
            3'd1:    period = 18'd170265;
            3'd2:    period = 18'd151685;
            3'd3:    period = 18'd143172;
            3'd4:    period = 18'd127551;
            3'd5:    period = 18'd113636;
            3'd6:    period = 18'd101239;
            default: period = 18'd95557;
        endcase
    endfunction

    always_comb begin
        is_next = key_flag && key_value == 3'b110;
        is_prev = key_flag && key_value == 3'b101;
        is_ply  = key_flag && key_value == 3'b011;
        start   = is_next || is_prev || (is_ply && state == IDLE);
        stop    = is_ply && state == PLAY;
        expire  = state == PLAY && dur_cnt == '0;
        note_n  = is_next ? note_idx + 3'd1 : is_prev ? note_idx - 3'd1 : note_idx;
        // an event in the expiry cycle wins over the expiry
        state_n = start ? PLAY : (stop || expire) ? IDLE : state;
        // note_n equals note_idx unless starting, and a start zeroes the phase anyway
        per     = period(note_n);
        pwm_n   = (start || state_n == IDLE || pwm_cnt == per - 18'd1) ? '0 : pwm_cnt + 18'd1;
        dur_n   = start ? DW'(BEEP_CYCLES - 1) : state_n == PLAY ? dur_cnt - DW'(1) : '0;
        // driven from next-state phase so beep lines up with busy
        beep_n  = state_n == PLAY && pwm_n < (per >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pwm_cnt  <= '0;
            dur_cnt  <= '0;
            note_idx <= '0;
            beep     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            pwm_cnt  <= pwm_n;
            dur_cnt  <= dur_n;
            note_idx <= note_n;
            beep     <= beep_n;
            busy     <= state_n == PLAY;
        end
    end
endmodule

// File: tb/tb_key_buzzer_ctrl.sv
// tb_key_buzzer_ctrl: directed bench for key_buzzer_ctrl; a long-duration instance
// for waveform timing and a short-duration instance for expiry and restart timing
module tb_key_buzzer_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_flag = 1'b0;
    logic [2:0] key_value = 3'b111;
    logic       l_beep, l_busy, s_beep, s_busy;
    logic [2:0] l_note, s_note;
    int         ncmp = 0;
    int         nerr = 0;

    typedef struct {
        logic       kf;
        logic [2:0] kv;
        logic [2:0] note;
        logic       busy;
        logic       beep;
    } vec_t;
    vec_t tbl[17];

    always #5 clk = ~clk;

    key_buzzer_ctrl #(.BEEP_CYCLES(48000)) u_long (
        .clk(clk), .rst_n(rst_n), .key_flag(key_flag), .key_value(key_value),
        .beep(l_beep), .note_idx(l_note), .busy(l_busy)
    );

    key_buzzer_ctrl #(.BEEP_CYCLES(16)) u_short (
        .clk(clk), .rst_n(rst_n), .key_flag(key_flag), .key_value(key_value),
        .beep(s_beep), .note_idx(s_note), .busy(s_busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [2:0] v);
        key_flag  = 1'b1;
        key_value = v;
        step();
        key_flag  = 1'b0;
        key_value = 3'b111;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        tbl[0]  = '{1'b0, 3'b110, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3'b111, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 3'b100, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 3'b000, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 3'b011, 3'd0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 3'b111, 3'd0, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 3'b011, 3'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 3'b101, 3'd7, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 3'b110, 3'd0, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 3'b110, 3'd1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 3'b101, 3'd1, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 3'b101, 3'd0, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 3'b011, 3'd0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 3'b011, 3'd0, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 3'b011, 3'd0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 3'b110, 3'd1, 1'b1, 1'b1};
        tbl[16] = '{1'b1, 3'b011, 3'd1, 1'b0, 1'b0};

        step();
        step();
        chk("reset_note", l_note, 0);
        chk("reset_busy", l_busy, 0);
        chk("reset_beep", l_beep, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            key_flag  = tbl[i].kf;
            key_value = tbl[i].kv;
            step();
            chk($sformatf("vec%0d_note", i), l_note, tbl[i].note);
            chk($sformatf("vec%0d_busy", i), l_busy, tbl[i].busy);
            chk($sformatf("vec%0d_beep", i), l_beep, tbl[i].beep);
        end
        key_flag  = 1'b0;
        key_value = 3'b111;

        strobe(3'b101);
        repeat (3) step();
        chk("pre_areset_busy", l_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_note", l_note, 0);
        chk("areset_busy", l_busy, 0);
        chk("areset_beep", l_beep, 0);
        step();
        rst_n = 1'b1;

        do_reset();
        strobe(3'b110);
        chk("s_start_note", s_note, 1);
        chk("s_start_busy", s_busy, 1);
        chk("s_start_beep", s_beep, 1);
        for (int k = 1; k < 16; k++) begin
            step();
            chk($sformatf("s_play%0d_busy", k), s_busy, 1);
        end
        step();
        chk("s_expire_busy", s_busy, 0);
        chk("s_expire_beep", s_beep, 0);
        chk("s_expire_note", s_note, 1);

        strobe(3'b011);
        chk("s_play_busy", s_busy, 1);
        repeat (5) step();
        strobe(3'b011);
        chk("s_stop_busy", s_busy, 0);
        chk("s_stop_beep", s_beep, 0);

        strobe(3'b011);
        repeat (15) step();
        chk("s_last_busy", s_busy, 1);
        strobe(3'b110);
        chk("s_expev_busy", s_busy, 1);
        chk("s_expev_note", s_note, 2);
        chk("s_expev_beep", s_beep, 1);
        for (int k = 1; k < 16; k++) begin
            step();
            chk($sformatf("s_expev%0d_busy", k), s_busy, 1);
        end
        step();
        chk("s_expev_end_busy", s_busy, 0);

        strobe(3'b101);
        repeat (4) step();
        strobe(3'b110);
        chk("s_rst_note", s_note, 2);
        for (int k = 1; k < 16; k++) begin
            step();
            chk($sformatf("s_rst%0d_busy", k), s_busy, 1);
        end
        step();
        chk("s_rst_end_busy", s_busy, 0);

        do_reset();
        strobe(3'b101);
        chk("l_wrap_note", l_note, 7);
        chk("l_wrap_beep", l_beep, 1);
        cnt = 1;
        while (cnt < 60000) begin
            step();
            if (!l_beep) break;
            cnt++;
        end
        chk("l_note7_high", cnt, 47778);
        chk("l_note7_busy", l_busy, 1);
        repeat (20) step();
        chk("l_low_beep", l_beep, 0);
        strobe(3'b110);
        chk("l_next_wrap_note", l_note, 0);
        strobe(3'b101);
        chk("l_phase_note", l_note, 7);
        chk("l_phase_beep", l_beep, 1);
        chk("l_phase_busy", l_busy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
